pipe_writeback: RTL and testbench

MEM/WB pipeline register and write-back data formatter for the pipelined MIPS core. It captures EX/MEM results and load read data, aligns and extends sub-word loads (LB/LBU/LH/LHU/LW/LWL/LWR), and selects among ALU, memory and link sources. It drives the register-file write port (MEM_WB_Instruction, MEM_WB_RegWrite, MEM_WB_RegWriteDst, RegWriteEn) and keeps a retired-instruction count.

---
 rtl/pipe_writeback_if.sv | 62 ++++++
 rtl/pipe_writeback.sv | 156 +++++++++++++++
 tb/tb_pipe_writeback.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_writeback_if.sv
// ---------------------------------------------------------------------------
// pipe_writeback_if
// Bundles the EX/MEM capture inputs, the pipeline control (stall/flush) and
// the MEM/WB register-file write-port outputs of pipe_writeback.
//   master : MEM stage / environment side (drives EX_MEM_*, mem_readdata,
//            waitrequest, flush; observes MEM_WB_*, RegWriteEn, RetireCount)
//   slave  : pipe_writeback itself
// Optional macro WB_BYPASS_EN adds the ID-stage bypass signals
// (IF_ID_Instruction, RegData1, RegData2 in; BypassRs, BypassRt out).
// ---------------------------------------------------------------------------
interface pipe_writeback_if;
    logic        waitrequest;
    logic        flush;
    logic        EX_MEM_Valid;
    logic [31:0] EX_MEM_Instruction;
    logic [31:0] EX_MEM_ALUResult;
    logic [31:0] EX_MEM_PC;
    logic [31:0] EX_MEM_RtData;
    logic        EX_MEM_RegWriteEn;
    logic [1:0]  EX_MEM_RegWriteDst;
    logic [1:0]  EX_MEM_WBSel;
    logic [31:0] mem_readdata;

    logic [31:0] MEM_WB_Instruction;
    logic [31:0] MEM_WB_RegWrite;
    logic [1:0]  MEM_WB_RegWriteDst;
    logic        RegWriteEn;
    logic        MEM_WB_Valid;
    logic [31:0] RetireCount;

`ifdef WB_BYPASS_EN
    logic [31:0] IF_ID_Instruction;
    logic [31:0] RegData1;
    logic [31:0] RegData2;
    logic [31:0] BypassRs;
    logic [31:0] BypassRt;
`endif

    modport master (
        output waitrequest, flush, EX_MEM_Valid, EX_MEM_Instruction,
               EX_MEM_ALUResult, EX_MEM_PC, EX_MEM_RtData, EX_MEM_RegWriteEn,
               EX_MEM_RegWriteDst, EX_MEM_WBSel, mem_readdata,
        input  MEM_WB_Instruction, MEM_WB_RegWrite, MEM_WB_RegWriteDst,
               RegWriteEn, MEM_WB_Valid, RetireCount
`ifdef WB_BYPASS_EN
        , output IF_ID_Instruction, RegData1, RegData2
        , input  BypassRs, BypassRt
`endif
    );

    modport slave (
        input  waitrequest, flush, EX_MEM_Valid, EX_MEM_Instruction,
               EX_MEM_ALUResult, EX_MEM_PC, EX_MEM_RtData, EX_MEM_RegWriteEn,
               EX_MEM_RegWriteDst, EX_MEM_WBSel, mem_readdata,
        output MEM_WB_Instruction, MEM_WB_RegWrite, MEM_WB_RegWriteDst,
               RegWriteEn, MEM_WB_Valid, RetireCount
`ifdef WB_BYPASS_EN
        , input  IF_ID_Instruction, RegData1, RegData2
        , output BypassRs, BypassRt
`endif
    );
endinterface

// File: rtl/pipe_writeback.sv
// ---------------------------------------------------------------------------
// pipe_writeback
// MEM/WB pipeline register and write-back formatter for the pipelined MIPS
// core. Captures the EX/MEM slot, formats sub-word loads
// (LB/LBU/LH/LHU/LW/LWL/LWR), selects ALU / memory / link data and drives the
// register-file write port. Also counts retired (captured valid) instructions.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high; priority over stall and flush
//   bus    : pipe_writeback_if.slave (EX/MEM inputs, MEM/WB outputs)
// Parameter LINK_OFFSET: byte offset added to the PC for link writes.
// Optional macro WB_BYPASS_EN: combinational ID-stage bypass of the
// registered write-back value (BypassRs/BypassRt).
// All outputs are registered except the optional bypass outputs.
// ---------------------------------------------------------------------------
module pipe_writeback #(
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input logic           clk,
    input logic           reset,
    pipe_writeback_if.slave bus
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;

    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;

    // Registered MEM/WB state
    logic [31:0] instr_q;
    logic [31:0] data_q;
    logic [1:0]  dst_q;
    logic        wen_q;
    logic        valid_q;
    logic [31:0] retire_cnt;

    // Load formatting
    logic [5:0]  opcode;
    logic [1:0]  k;
    logic [31:0] rdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [4:0]  lwl_sh;
    logic [4:0]  lwr_sh;
    logic [31:0] mem_data;
    logic [31:0] wb_data;
    logic        dest_is_zero;

    assign opcode = bus.EX_MEM_Instruction[31:26];
    assign k      = bus.EX_MEM_ALUResult[1:0];
    assign rdata  = bus.mem_readdata;

    assign load_byte = 8'(rdata >> {k, 3'b000});
    assign load_half = k[1] ? rdata[31:16] : rdata[15:0];
    // 8*(3-k) equals 8*~k for a 2-bit k.
    assign lwl_sh    = {~k, 3'b000};
    assign lwr_sh    = {k, 3'b000};

    // NOTE: every variable assigned in an always_comb gets a default first so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        mem_data = rdata;
        unique case (opcode)
            OP_LB:   mem_data = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  mem_data = {24'h0, load_byte};
            OP_LH:   mem_data = {{16{load_half[15]}}, load_half};
            OP_LHU:  mem_data = {16'h0, load_half};
            OP_LWL:  mem_data = (rdata << lwl_sh)
                              | (bus.EX_MEM_RtData & ~(32'hFFFF_FFFF << lwl_sh));
            OP_LWR:  mem_data = (rdata >> lwr_sh)
                              | (bus.EX_MEM_RtData & ~(32'hFFFF_FFFF >> lwr_sh));
            default: mem_data = rdata;
        endcase
    end

    always_comb begin
        wb_data = bus.EX_MEM_ALUResult;
        case (bus.EX_MEM_WBSel)
            WB_MEM:  wb_data = mem_data;
            WB_LINK: wb_data = bus.EX_MEM_PC + LINK_OFFSET;
            default: wb_data = bus.EX_MEM_ALUResult;  // ALU and reserved 11
        endcase
    end

    // A write to r0 is architecturally a no-op; suppress it at the port.
    assign dest_is_zero =
        ((bus.EX_MEM_RegWriteDst == DST_RT) && (bus.EX_MEM_Instruction[20:16] == 5'd0)) ||
        ((bus.EX_MEM_RegWriteDst == DST_RD) && (bus.EX_MEM_Instruction[15:11] == 5'd0));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= '0;
            data_q     <= '0;
            dst_q      <= '0;
            wen_q      <= 1'b0;
            valid_q    <= 1'b0;
            retire_cnt <= '0;
        end else if (!bus.waitrequest) begin
            if (bus.flush || !bus.EX_MEM_Valid) begin
                instr_q <= '0;
                data_q  <= '0;
                dst_q   <= '0;
                wen_q   <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                instr_q    <= bus.EX_MEM_Instruction;
                data_q     <= wb_data;
                dst_q      <= bus.EX_MEM_RegWriteDst;
                wen_q      <= bus.EX_MEM_RegWriteEn && !dest_is_zero;
                valid_q    <= 1'b1;
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    assign bus.MEM_WB_Instruction = instr_q;
    assign bus.MEM_WB_RegWrite    = data_q;
    assign bus.MEM_WB_RegWriteDst = dst_q;
    assign bus.RegWriteEn         = wen_q;
    assign bus.MEM_WB_Valid       = valid_q;
    assign bus.RetireCount        = retire_cnt;

`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle to the ID-stage read so a
    // same-edge write/read of the register file sees the new data.
    logic [4:0] wr_addr;
    logic       rs_hit;
    logic       rt_hit;

    always_comb begin
        wr_addr = 5'd0;
        case (dst_q)
            DST_RT:  wr_addr = instr_q[20:16];
            DST_RD:  wr_addr = instr_q[15:11];
            2'b10:   wr_addr = 5'd31;
            default: wr_addr = 5'd0;
        endcase
    end

    assign rs_hit = wen_q && (wr_addr != 5'd0) && (wr_addr == bus.IF_ID_Instruction[25:21]);
    assign rt_hit = wen_q && (wr_addr != 5'd0) && (wr_addr == bus.IF_ID_Instruction[20:16]);

    assign bus.BypassRs = rs_hit ? data_q : bus.RegData1;
    assign bus.BypassRt = rt_hit ? data_q : bus.RegData2;
`endif
endmodule

// File: tb/tb_pipe_writeback.sv
// ---------------------------------------------------------------------------
// tb_pipe_writeback
// Randomized and directed stimulus for pipe_writeback. Each clock edge the
// driver advances a byte-level reference model and queues the expected
// MEM/WB state; an independent monitor pops one entry per edge and compares.
// ---------------------------------------------------------------------------
module tb_pipe_writeback;
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] data;
        logic [1:0]  dst;
        logic        wen;
        logic        valid;
        logic [31:0] cnt;
    } wb_t;

    logic clk = 1'b0;
    logic reset;

    pipe_writeback_if bus ();

    pipe_writeback #(.LINK_OFFSET(LINK_OFFSET)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wb_t model_q;
    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference load formatting, worked out byte by byte.
    function automatic logic [31:0] model_load(input logic [31:0] instr, input logic [31:0] addr,
                                               input logic [31:0] rd, input logic [31:0] rt);
        logic [7:0] b[4];
        logic [7:0] r[4];
        logic [7:0] o[4];
        int kk;
        int hb;
        kk = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            b[i] = rd[8*i +: 8];
            r[i] = rt[8*i +: 8];
            o[i] = r[i];
        end
        hb = (kk / 2) * 2;
        case (instr[31:26])
            6'h20: return {{24{b[kk][7]}}, b[kk]};
            6'h24: return {24'h0, b[kk]};
            6'h21: return {{16{b[hb+1][7]}}, b[hb+1], b[hb]};
            6'h25: return {16'h0, b[hb+1], b[hb]};
            6'h22: begin
                for (int i = 0; i < 4; i++) if (i >= 3 - kk) o[i] = b[i - (3 - kk)];
                return {o[3], o[2], o[1], o[0]};
            end
            6'h26: begin
                for (int i = 0; i < 4; i++) if (i <= 3 - kk) o[i] = b[i + kk];
                return {o[3], o[2], o[1], o[0]};
            end
            default: return rd;
        endcase
    endfunction

    task automatic model_step();
        wb_t n;
        int  tgt;
        n = model_q;
        if (reset) begin
            n = '0;
        end else if (!bus.waitrequest) begin
            if (bus.flush || !bus.EX_MEM_Valid) begin
                n     = '0;
                n.cnt = model_q.cnt;
            end else begin
                n.instr = bus.EX_MEM_Instruction;
                n.dst   = bus.EX_MEM_RegWriteDst;
                n.valid = 1'b1;
                n.cnt   = model_q.cnt + 32'd1;
                tgt = (n.dst == 2'd0) ? int'(n.instr[20:16]) :
                      (n.dst == 2'd1) ? int'(n.instr[15:11]) : 31;
                n.wen = bus.EX_MEM_RegWriteEn && !((n.dst < 2'd2) && (tgt == 0));
                case (bus.EX_MEM_WBSel)
                    2'd1:    n.data = model_load(n.instr, bus.EX_MEM_ALUResult,
                                                 bus.mem_readdata, bus.EX_MEM_RtData);
                    2'd2:    n.data = bus.EX_MEM_PC + LINK_OFFSET;
                    default: n.data = bus.EX_MEM_ALUResult;
                endcase
            end
        end
        model_q = n;
        exp_q.push_back(n);
    endtask

    // One clock: record expectation for this edge, then step past it.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] rt, input logic [31:0] rd, input logic wen,
                         input logic [1:0] dst, input logic [1:0] wbsel);
        bus.waitrequest        = 1'b0;
        bus.flush              = 1'b0;
        bus.EX_MEM_Valid       = 1'b1;
        bus.EX_MEM_Instruction = instr;
        bus.EX_MEM_ALUResult   = alu;
        bus.EX_MEM_PC          = pc;
        bus.EX_MEM_RtData      = rt;
        bus.mem_readdata       = rd;
        bus.EX_MEM_RegWriteEn  = wen;
        bus.EX_MEM_RegWriteDst = dst;
        bus.EX_MEM_WBSel       = wbsel;
    endtask

    // Monitor: one expectation per clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                wb_t e;
                e = exp_q.pop_front();
                check("instr", bus.MEM_WB_Instruction, e.instr);
                check("wbdata", bus.MEM_WB_RegWrite, e.data);
                check("dst", 32'(bus.MEM_WB_RegWriteDst), 32'(e.dst));
                check("wen", 32'(bus.RegWriteEn), 32'(e.wen));
                check("valid", 32'(bus.MEM_WB_Valid), 32'(e.valid));
                check("retire", bus.RetireCount, e.cnt);
            end
        end
    end

    localparam logic [5:0] LOAD_OPS[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                            6'h25, 6'h26, 6'h00, 6'h0D, 6'h2B};

    initial begin
        logic [31:0] saved_cnt;
        logic [31:0] instr;
        model_q = '0;
        reset = 1'b1;
        drive('0, '0, '0, '0, '0, 1'b0, 2'd0, 2'd0);
        bus.EX_MEM_Valid = 1'b0;
`ifdef WB_BYPASS_EN
        bus.IF_ID_Instruction = '0;
        bus.RegData1 = '0;
        bus.RegData2 = '0;
`endif
        // 1: reset, then idle slot
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        check("idle_valid", 32'(bus.MEM_WB_Valid), 32'd0);
        check("idle_retire", bus.RetireCount, 32'd0);

        // 2: sub-word loads
        drive({6'h20, 5'd1, 5'd5, 16'h0}, 32'h1003, '0, '0, 32'h80FF1234, 1'b1, 2'd0, 2'd1);
        cycle();
        check("lb", bus.MEM_WB_RegWrite, 32'hFFFFFF80);
        drive({6'h24, 5'd1, 5'd5, 16'h0}, 32'h1003, '0, '0, 32'h80FF1234, 1'b1, 2'd0, 2'd1);
        cycle();
        check("lbu", bus.MEM_WB_RegWrite, 32'h00000080);
        drive({6'h25, 5'd1, 5'd5, 16'h0}, 32'h1002, '0, '0, 32'h80FF1234, 1'b1, 2'd0, 2'd1);
        cycle();
        check("lhu", bus.MEM_WB_RegWrite, 32'h000080FF);

        // 3: unaligned merges
        drive({6'h22, 5'd1, 5'd5, 16'h0}, 32'h2001, '0, 32'h11223344, 32'hAABBCCDD, 1'b1, 2'd0, 2'd1);
        cycle();
        check("lwl", bus.MEM_WB_RegWrite, 32'hCCDD3344);
        drive({6'h26, 5'd1, 5'd5, 16'h0}, 32'h2001, '0, 32'h11223344, 32'hAABBCCDD, 1'b1, 2'd0, 2'd1);
        cycle();
        check("lwr", bus.MEM_WB_RegWrite, 32'h11AABBCC);

        // 4: link and r0 suppression
        drive({6'h03, 26'h0100}, '0, 32'hBFC00010, '0, '0, 1'b1, 2'd2, 2'd2);
        cycle();
        check("jal_data", bus.MEM_WB_RegWrite, 32'hBFC00018);
        check("jal_dst", 32'(bus.MEM_WB_RegWriteDst), 32'd2);
        check("jal_wen", 32'(bus.RegWriteEn), 32'd1);
        drive({6'h00, 5'd2, 5'd3, 5'd0, 11'h020}, 32'h55, '0, '0, '0, 1'b1, 2'd1, 2'd0);
        cycle();
        check("rd0_wen", 32'(bus.RegWriteEn), 32'd0);

        // 5: stall and flush
        drive({6'h00, 5'd2, 5'd3, 5'd4, 11'h020}, 32'h1234, '0, '0, '0, 1'b1, 2'd1, 2'd0);
        cycle();
        saved_cnt = model_q.cnt;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, $urandom, $urandom, $urandom, 1'b1, 2'd1, 2'd0);
            bus.waitrequest = 1'b1;
            bus.flush = (i == 1);
            cycle();
            check("stall_data", bus.MEM_WB_RegWrite, 32'h1234);
            check("stall_retire", bus.RetireCount, saved_cnt);
        end
        drive({6'h00, 5'd2, 5'd3, 5'd4, 11'h020}, 32'h9999, '0, '0, '0, 1'b1, 2'd1, 2'd0);
        bus.flush = 1'b1;
        cycle();
        check("flush_valid", 32'(bus.MEM_WB_Valid), 32'd0);
        check("flush_retire", bus.RetireCount, saved_cnt);

        // 6: counter wrap (preloaded through the hierarchy)
        dut.retire_cnt = 32'hFFFF_FFFF;
        model_q.cnt = 32'hFFFF_FFFF;
        drive({6'h00, 5'd2, 5'd3, 5'd4, 11'h020}, 32'h1, '0, '0, '0, 1'b1, 2'd1, 2'd0);
        cycle();
        check("wrap", bus.RetireCount, 32'd0);

`ifdef WB_BYPASS_EN
        drive({6'h00, 5'd2, 5'd3, 5'd5, 11'h020}, 32'hCAFE0005, '0, '0, '0, 1'b1, 2'd1, 2'd0);
        cycle();
        bus.IF_ID_Instruction = {6'h00, 5'd5, 5'd7, 16'h0};
        bus.RegData1 = 32'h1111_1111;
        bus.RegData2 = 32'h2222_2222;
        #1;
        check("byp_rs_hit", bus.BypassRs, 32'hCAFE0005);
        check("byp_rt_miss", bus.BypassRt, 32'h2222_2222);
        drive({6'h00, 5'd2, 5'd0, 16'h0}, 32'hDEAD0000, '0, '0, '0, 1'b1, 2'd0, 2'd0);
        cycle();
        bus.IF_ID_Instruction = '0;
        #1;
        check("byp_r0_rs", bus.BypassRs, 32'h1111_1111);
        check("byp_r0_rt", bus.BypassRt, 32'h2222_2222);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            instr = $urandom;
            instr[31:26] = LOAD_OPS[$urandom_range(0, 9)];
            drive(instr, $urandom, $urandom, $urandom, $urandom, 1'($urandom),
                  2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)));
            bus.waitrequest  = ($urandom_range(0, 4) == 0);
            bus.flush        = ($urandom_range(0, 9) == 0);
            bus.EX_MEM_Valid = ($urandom_range(0, 7) != 0);
            reset            = ($urandom_range(0, 99) == 0);
            cycle();
`ifdef WB_BYPASS_EN
            begin
                int tgt;
                logic [31:0] id_ins;
                logic [31:0] r1;
                logic [31:0] r2;
                tgt = (model_q.dst == 2'd0) ? int'(model_q.instr[20:16]) :
                      (model_q.dst == 2'd1) ? int'(model_q.instr[15:11]) :
                      (model_q.dst == 2'd2) ? 31 : 0;
                id_ins = $urandom;
                if ($urandom_range(0, 1) == 1) id_ins[25:21] = 5'(tgt);
                r1 = $urandom;
                r2 = $urandom;
                bus.IF_ID_Instruction = id_ins;
                bus.RegData1 = r1;
                bus.RegData2 = r2;
                #1;
                check("rnd_byp_rs", bus.BypassRs,
                      (model_q.wen && tgt != 0 && int'(id_ins[25:21]) == tgt) ? model_q.data : r1);
                check("rnd_byp_rt", bus.BypassRt,
                      (model_q.wen && tgt != 0 && int'(id_ins[20:16]) == tgt) ? model_q.data : r2);
            end
`endif
        end
        reset = 1'b0;
        bus.waitrequest = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
